// File: rtl/serial_arith_pkg.sv
// serial_arith_pkg: shared widths and FSM state encoding for the serial arithmetic datapath.
package serial_arith_pkg;
   localparam int SER_WIDTH    = 16;
   localparam int SER_DIV_BITS = 32;
   typedef enum logic {DIV_IDLE, DIV_RUN} div_state_e;
endpackage

// File: rtl/serial_div16_if.sv
// serial_div16_if: frame control, serial dividend/quotient and parallel remainder bundle.
interface serial_div16_if import serial_arith_pkg::*; #(parameter int WIDTH = SER_WIDTH);
   logic             start;
   logic [WIDTH-1:0] divisor;
   logic             din;
   logic             din_valid;
   logic             dout;
   logic             dout_valid;
   logic [WIDTH-1:0] remainder;
   logic             rem_valid;
   logic             busy;
   logic             div_zero;
   modport master (output start, divisor, din, din_valid,
                   input dout, dout_valid, remainder, rem_valid, busy, div_zero);
   modport slave (input start, divisor, din, din_valid,
                  output dout, dout_valid, remainder, rem_valid, busy, div_zero);
endinterface

// File: rtl/serial_div16_div_step.sv
// div_step: one restoring-division step, shifting a dividend bit into the partial remainder.
module div_step #(parameter int WIDTH = 16) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic             bit_i,
   input  logic [WIDTH-1:0] dsr_i,
   output logic             q_o,
   output logic [WIDTH-1:0] rem_next_o
);
   logic [WIDTH:0]   p;
   logic [WIDTH-1:0] diff;
   assign p    = {rem_i, bit_i};
   // rem_i < dsr_i keeps the true difference inside WIDTH bits
   assign diff = p[WIDTH-1:0] - dsr_i;
   assign q_o  = p >= {1'b0, dsr_i};
   assign rem_next_o = q_o ? diff : p[WIDTH-1:0];
endmodule

// File: rtl/serial_div16.sv
// serial_div16: bit-serial restoring divider, MSB-first dividend in, MSB-first quotient out.
module serial_div16 import serial_arith_pkg::*; #(
   parameter int WIDTH    = SER_WIDTH,
   parameter int DIV_BITS = SER_DIV_BITS
) (
   input logic           clk,
   input logic           rst_n,
   serial_div16_if.slave bus
);
   localparam int CNT_W = $clog2(DIV_BITS + 1);
   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_q, dsr_q, remainder_q, rem_next;
   logic             dout_q, dout_valid_q, rem_valid_q, div_zero_q, busy;
   logic             q, accept, last;
   // start always wins over a coincident dividend bit
   assign accept = (state_q == DIV_RUN) && bus.din_valid && !bus.start;
   assign last   = cnt_q == CNT_W'(DIV_BITS - 1);
   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i(rem_q), .bit_i(bus.din), .dsr_i(dsr_q), .q_o(q), .rem_next_o(rem_next)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= DIV_IDLE;
      else        state_q <= state_d;
   always_comb
      state_d = bus.start ? DIV_RUN : (accept && last) ? DIV_IDLE : state_q;
   always_comb
      busy = state_q == DIV_RUN;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         cnt_q        <= '0;
         rem_q        <= '0;
         dsr_q        <= '0;
         remainder_q  <= '0;
         dout_q       <= 1'b0;
         dout_valid_q <= 1'b0;
         rem_valid_q  <= 1'b0;
         div_zero_q   <= 1'b0;
      end else begin
         dout_valid_q <= accept;
         rem_valid_q  <= accept && last;
         if (bus.start) begin
            dsr_q      <= bus.divisor;
            rem_q      <= '0;
            cnt_q      <= '0;
            div_zero_q <= bus.divisor == '0;
         end else if (accept) begin
            dout_q <= q;
            rem_q  <= rem_next;
            cnt_q  <= cnt_q + 1'b1;
            if (last) remainder_q <= rem_next;
         end
      end
   assign bus.dout       = dout_q;
   assign bus.dout_valid = dout_valid_q;
   assign bus.remainder  = remainder_q;
   assign bus.rem_valid  = rem_valid_q;
   assign bus.busy       = busy;
   assign bus.div_zero   = div_zero_q;
endmodule

// File: tb/tb_serial_div16.sv
// tb_serial_div16: directed frames with a quotient/remainder scoreboard drained by a monitor.
module tb_serial_div16;
   typedef struct packed {
      logic        q;
      logic        last;
      logic [15:0] rem;
      logic        dz;
   } exp_t;
   logic   clk = 1'b0;
   logic   rst_n = 1'b0;
   int     total = 0;
   int     bad = 0;
   int     nvalid = 0;
   exp_t   sb[$];
   serial_div16_if bus();
   serial_div16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (rst_n && bus.dout_valid) begin
         if (sb.size() == 0) chk("unexpected_dout_valid", 32'd1, 32'd0);
         else begin
            exp_t e;
            e = sb.pop_front();
            nvalid++;
            chk("dout", {31'd0, bus.dout}, {31'd0, e.q});
            chk("rem_valid", {31'd0, bus.rem_valid}, {31'd0, e.last});
            if (e.last) begin
               chk("remainder", {16'd0, bus.remainder}, {16'd0, e.rem});
               chk("div_zero", {31'd0, bus.div_zero}, {31'd0, e.dz});
            end
         end
      end else if (rst_n && bus.rem_valid)
         chk("rem_valid_without_dout", 32'd1, 32'd0);
   end
   task automatic do_start(input logic [15:0] d, input logic dv, input logic db);
      nvalid = 0;
      bus.start = 1'b1;
      bus.divisor = d;
      bus.din_valid = dv;
      bus.din = db;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.din_valid = 1'b0;
      chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
   endtask
   task automatic feed(input logic [31:0] dd, input logic [31:0] eq, input logic [15:0] er,
                       input logic dz, input int n, input int gap_pct);
      for (int i = 0; i < n; i++) begin
         while ($urandom_range(99) < gap_pct) begin
            bus.din_valid = 1'b0;
            bus.din = $urandom_range(1);
            @(posedge clk); #1;
         end
         bus.din = dd[31-i];
         bus.din_valid = 1'b1;
         sb.push_back('{q: eq[31-i], last: (i == 31), rem: er, dz: dz});
         @(posedge clk); #1;
         bus.din_valid = 1'b0;
      end
   endtask
   task automatic end_frame(input string name);
      chk({name, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
      @(negedge clk); #1;
      chk({name, "_dout_valid_count"}, nvalid, 32);
      chk({name, "_sb_empty"}, sb.size(), 0);
   endtask
   task automatic frame(input string name, input logic [15:0] d, input logic [31:0] dd,
                        input logic [31:0] eq, input logic [15:0] er, input int gap_pct);
      do_start(d, 1'b0, 1'b0);
      feed(dd, eq, er, d == 16'd0, 32, gap_pct);
      end_frame(name);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end
   initial begin
      bus.start = 1'b0;
      bus.divisor = '0;
      bus.din = 1'b0;
      bus.din_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {11'd0, bus.dout, bus.dout_valid, bus.remainder, bus.rem_valid,
                            bus.busy, bus.div_zero}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      frame("div100by7", 16'd7, 32'h0000_0064, 32'h0000_000E, 16'd2, 0);
      frame("large", 16'hFFFF, 32'hFFFF_FFFF, 32'h0001_0001, 16'd0, 0);
      frame("large_gaps", 16'hFFFF, 32'hFFFF_FFFF, 32'h0001_0001, 16'd0, 30);
      frame("divzero", 16'd0, 32'h1234_ABCD, 32'hFFFF_FFFF, 16'hABCD, 0);
      do_start(16'hFFFF, 1'b0, 1'b0);
      feed(32'hFFFF_FFFF, 32'h0001_0001, 16'd0, 1'b0, 10, 0);
      @(negedge clk); #1;
      frame("restart", 16'd10, 32'h0000_03E8, 32'h0000_0064, 16'd0, 0);
      do_start(16'd7, 1'b0, 1'b0);
      feed(32'h0000_0064, 32'h0000_000E, 16'd2, 1'b0, 5, 0);
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midframe_reset_outputs", {11'd0, bus.dout, bus.dout_valid, bus.remainder,
                                     bus.rem_valid, bus.busy, bus.div_zero}, 32'd0);
      chk("midframe_reset_sb_empty", sb.size(), 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("after_reset_idle", {31'd0, bus.busy}, 32'd0);
      frame("after_reset", 16'd255, 32'h0000_FFFF, 32'h0000_0101, 16'd0, 0);
      do_start(16'd7, 1'b1, 1'b1);
      feed(32'h0000_0064, 32'h0000_000E, 16'd2, 1'b0, 32, 0);
      end_frame("collision");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
